// File: rtl/ssa_ntt_seq_if.sv
// ---------------------------------------------------------------------------
// ssa_ntt_seq_if
//   Bundles the operand and result handshakes of ssa_ntt_seq.
//
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both 1. The producer holds its data stable
//   while valid is high and ready is low. The consumer may drive ready
//   without waiting for valid.
//
//   Signals
//     in_valid  : producer offers in_data / is_inv
//     in_ready  : block can accept an operand vector
//     is_inv    : 1 = inverse transform, sampled together with in_data
//     in_data   : N slots of M+1 bits, slot i = [i*(M+1) +: M+1]
//     out_valid : out_data holds a finished transform
//     out_ready : consumer accepts out_data
//     out_data  : N result slots, natural order, each < 2^M+1
//
//   Modports
//     master : operand producer / result consumer side
//     slave  : the transform block
// ---------------------------------------------------------------------------
interface ssa_ntt_seq_if #(
  parameter int LOG2N = 3,
  parameter int M     = 8
);
  localparam int N  = 1 << LOG2N;
  localparam int DW = N * (M + 1);

  logic          in_valid;
  logic          in_ready;
  logic          is_inv;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, is_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, is_inv, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ssa_ntt_seq.sv
// ---------------------------------------------------------------------------
// ssa_ntt_seq
//   Sequential number-theoretic transform over the ring Z/(2^M+1), as used
//   by Schoenhage-Strassen multiplication. One radix-2 DIT butterfly is
//   computed per clock; twiddle multiplications are pure shifts because
//   every twiddle is a power of two modulo 2^M+1.
//
//   Parameters
//     LOG2N : log2 of the number of points N
//     M     : modulus is P = 2^M+1, each slot is M+1 bits; 2M must be a
//             multiple of N
//
//   Ports
//     clk       : sole clock, rising edge
//     rst_n     : synchronous active-low reset
//     bus       : ssa_ntt_seq_if.slave (operand in / result out handshake)
//     state_dbg : current FSM state (0 IDLE, 1 COMPUTE, 2 SCALE, 3 DONE)
//
//   Optional feature
//     SSA_NTT_INV_EN : when defined, is_inv selects the inverse transform
//                      (negated twiddle exponents plus a final scaling by
//                      N^-1). When undefined, is_inv is ignored and only
//                      the forward transform is built.
//
//   Timing (accepting edge = edge 0)
//     edges 1..N/2*LOG2N : one butterfly each
//     forward            : DONE entered on the last butterfly edge,
//                          out_valid rises one edge later
//     inverse            : one extra edge for the SCALE pass
// ---------------------------------------------------------------------------
module ssa_ntt_seq #(
  parameter int LOG2N = 3,
  parameter int M     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  ssa_ntt_seq_if.slave    bus,
  output logic [1:0]      state_dbg
);

  localparam int N   = 1 << LOG2N;
  localparam int W   = M + 1;
  localparam int K   = (2 * M) / N;            // exponent step of the N-th root
  localparam int IW  = LOG2N;                  // slot index width
  localparam int KW  = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int SW  = $clog2(LOG2N + 1);
  localparam int EW  = $clog2(2 * M + 1);      // twiddle exponent width

  localparam logic [W-1:0]  P      = W'((1 << M) + 1);
  localparam logic [EW-1:0] M_E    = EW'(M);
  localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
`ifdef SSA_NTT_INV_EN
  localparam logic [EW-1:0] TWO_M  = EW'(2 * M);
  // N^-1 mod P = 2^(2M-LOG2N) because 2^(2M) = 1 mod P
  localparam logic [EW-1:0] SC_E   = EW'(2 * M - LOG2N);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SCALE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Modular helpers; all operands are already in [0, P-1]
  // -------------------------------------------------------------------------
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    if (a >= b) return a - b;
    return W'({1'b0, a} + {1'b0, P} - {1'b0, b});
  endfunction

  function automatic logic [W-1:0] mod_neg(input logic [W-1:0] a);
    if (a == '0) return '0;
    return P - a;
  endfunction

  // Raw input slots may exceed P-1; one subtraction suffices for M+1 bits.
  function automatic logic [W-1:0] reduce(input logic [W-1:0] a);
    if (a >= P) return a - P;
    return a;
  endfunction

  // 2^e * b mod P for e in [0, 2M). The shifted value is split at bit M:
  // since 2^M = -1 mod P, the result is low - high. For e >= M the factor
  // 2^M is pulled out as a negation.
  function automatic logic [W-1:0] mod_pow2(input logic [W-1:0]  b,
                                            input logic [EW-1:0] e);
    logic [EW-1:0]  sh;
    logic [2*M:0]   v;
    logic [W-1:0]   r;
    sh = (e >= M_E) ? e - M_E : e;
    v  = {{M{1'b0}}, b} << sh;
    r  = mod_sub({1'b0, v[M-1:0]}, v[2*M:M]);
    if (e >= M_E) r = mod_neg(r);
    return r;
  endfunction

  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] i);
    logic [IW-1:0] r;
    for (int b = 0; b < IW; b++) r[b] = i[IW-1-b];
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [W-1:0]   slot_q [N];
  logic [W-1:0]   slot_d [N];
  logic [SW-1:0]  stage_q, stage_d;            // stage s-1
  logic [KW-1:0]  k_q, k_d;                    // butterfly index in stage
  logic           out_valid_q, out_valid_d;
`ifdef SSA_NTT_INV_EN
  logic           inv_q, inv_d;
`endif

  // Butterfly addressing and twiddle
  logic [IW-1:0]  hh, jj, top_i, bot_i;
  logic [EW-1:0]  e_fwd, e_use;
  logic [W-1:0]   bf_a, bf_t;
  logic           last_bf;

  // -------------------------------------------------------------------------
  // Butterfly addressing: k = group*h + j, top = group*2h + j, bot = top + h
  // -------------------------------------------------------------------------
  always_comb begin
    hh    = IW'(1) << stage_q;
    jj    = IW'(k_q) & (hh - IW'(1));
    top_i = ((IW'(k_q) >> stage_q) << (stage_q + SW'(1))) | jj;
    bot_i = top_i | hh;
    // e = j * (N/2h) * (2M/N); j < h keeps this below M, so no mod 2M
    // reduction is ever needed on the forward exponent.
    e_fwd = EW'((32'(jj) << (LOG2N - 1 - 32'(stage_q))) * K);
`ifdef SSA_NTT_INV_EN
    e_use = (inv_q && e_fwd != '0) ? TWO_M - e_fwd : e_fwd;
`else
    e_use = e_fwd;
`endif
    bf_a    = slot_q[top_i];
    bf_t    = mod_pow2(slot_q[bot_i], e_use);
    last_bf = (stage_q == S_LAST) && (k_q == K_LAST);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.in_valid) state_d = ST_COMPUTE;
      ST_COMPUTE: if (last_bf) begin
`ifdef SSA_NTT_INV_EN
        state_d = inv_q ? ST_SCALE : ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
`ifdef SSA_NTT_INV_EN
      ST_SCALE:   state_d = ST_DONE;
`endif
      ST_DONE:    if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = out_valid_q;
    state_dbg     = state_q;
    bus.out_data  = '0;
    for (int i = 0; i < N; i++) bus.out_data[i*W +: W] = slot_q[i];
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N; i++) slot_d[i] = slot_q[i];
    stage_d = stage_q;
    k_d     = k_q;
    // out_valid follows DONE by one edge and drops on the accepting edge.
    out_valid_d = (state_q == ST_DONE) && !(out_valid_q && bus.out_ready);
`ifdef SSA_NTT_INV_EN
    inv_d = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Bit-reversed load makes the DIT result come out in natural order.
          for (int i = 0; i < N; i++)
            slot_d[bitrev(IW'(i))] = reduce(bus.in_data[i*W +: W]);
`ifdef SSA_NTT_INV_EN
          inv_d = bus.is_inv;
`endif
        end
      end
      ST_COMPUTE: begin
        slot_d[top_i] = mod_add(bf_a, bf_t);
        slot_d[bot_i] = mod_sub(bf_a, bf_t);
        if (k_q == K_LAST) begin
          k_d     = '0;
          stage_d = last_bf ? '0 : stage_q + SW'(1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
`ifdef SSA_NTT_INV_EN
      ST_SCALE: begin
        for (int i = 0; i < N; i++) slot_d[i] = mod_pow2(slot_q[i], SC_E);
      end
`endif
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) slot_q[i] <= '0;
      stage_q     <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef SSA_NTT_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N; i++) slot_q[i] <= slot_d[i];
      stage_q     <= stage_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
`ifdef SSA_NTT_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

endmodule

// File: doc/ssa_ntt_seq.md
SSA_NTT_SEQ -- requirements
Module: ssa_ntt_seq

Interface
REQ-001 Parameter LOG2N, default 3; number of transform points N = 2^LOG2N.
REQ-002 Parameter M, default 8; ring modulus P = 2^M+1; slot width M+1; 2M SHALL be a multiple of N.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  in_data/is_inv offered.
REQ-006 in_ready  output  1  block can accept an operand vector.
REQ-007 is_inv  input  1  1 = inverse transform, sampled with in_data.
REQ-008 in_data  input  N*(M+1)  slot i = bits [i*(M+1) +: M+1], natural order.
REQ-009 out_valid  output  1  out_data holds a finished transform.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  N*(M+1)  result slots, natural order, each < P.

Function
REQ-012 States IDLE, COMPUTE, SCALE, DONE; in_ready = 1 only in IDLE.
REQ-013 IDLE: on in_valid & in_ready, capture slots in bit-reversed index order, reducing any slot >= P by one subtraction of P, latch is_inv, go to COMPUTE.
REQ-014 COMPUTE: radix-2 decimation-in-time, exactly one butterfly per cycle, N/2*LOG2N cycles; stage s = 1..LOG2N, half-span h = 2^(s-1), groups in ascending order, j = 0..h-1 within group.
REQ-015 Twiddle exponent e = (j*(N/(2h))*(2M/N)) mod 2M; inverse uses (2M-e) mod 2M; w*b = 2^e*b mod P by shift, with negation mod P when e >= M; no multiplier.
REQ-016 Butterfly: a' = (a + w*b) mod P, b' = (a - w*b) mod P; all stored values remain in [0, P-1].
REQ-017 After the last butterfly: forward goes to DONE; inverse goes to SCALE.
REQ-018 SCALE: one cycle, every slot multiplied by N^-1 = 2^(2M-LOG2N) mod P (shift form), then DONE.
REQ-019 Latency: out_valid rises N/2*LOG2N+1 rising edges after the accepting edge (forward), one more for inverse; N=8, M=8: 13 forward, 14 inverse.
REQ-020 DONE: out_valid = 1, out_data stable until out_valid & out_ready, then IDLE with out_valid = 0 on the next edge.
REQ-021 in_valid while not IDLE is ignored; no operand is queued.
REQ-022 out_data equals the working register file; values are undefined-free (zero) before the first result.

Reset
REQ-023 rst_n = 0 on a rising edge SHALL force IDLE, in_ready = 1 on the next cycle, out_valid = 0, out_data = 0, all counters and latched is_inv = 0.
REQ-024 Reset mid-COMPUTE, mid-SCALE or in DONE SHALL discard the operation; no partial result is ever presented.

Configuration
REQ-025 Macro SSA_NTT_INV_EN: defined -> is_inv honoured, inverse twiddles and SCALE state built.
REQ-026 Undefined -> is_inv ignored (treated as 0), SCALE state and inverse twiddle logic absent, latency always forward value.

Verification
REQ-027 N=8, M=8, forward, x=[1,0,0,0,0,0,0,0] -> out all slots 1, out_valid at edge 13.
REQ-028 Forward, x=[0,1,0,...,0] -> X = [1,4,16,64,256,253,241,193].
REQ-029 Forward x = all 1 -> [8,0,0,0,0,0,0,0]; inverse of that (SSA_NTT_INV_EN) -> all 1, out_valid at edge 14.
REQ-030 Input slots 257 and 300 -> treated as 0 and 43; random vector forward then inverse returns original reduced vector.
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_data unchanged, in_ready = 0, in_valid pulses ignored; accept on 6th cycle -> IDLE next edge.
REQ-032 rst_n = 0 at cycle 6 of COMPUTE -> next cycle IDLE, out_valid 0, out_data 0; new operand then processes with full latency.
